// File: rtl/line_i_cache.sv
// Direct-mapped instruction cache: one outstanding fetch, whole-line refill over a word bus.
// Optional hit/miss counters built only when LINE_I_CACHE_PERF_EN is defined.
module line_i_cache #(
    parameter int data_width  = 32,
    parameter int addr_width  = 32,
    parameter int entries     = 16,
    parameter int line_words  = 4,
    parameter int count_width = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   ir_addr_valid,
    output logic                   ir_addr_ready,
    input  logic [addr_width-1:0]  ir_addr,
    output logic                   ir_data_valid,
    input  logic                   ir_data_ready,
    output logic [data_width-1:0]  ir_data,
    output logic                   bus_ir_addr_valid,
    input  logic                   bus_ir_addr_ready,
    output logic [addr_width-1:0]  bus_ir_addr,
    input  logic                   bus_ir_data_valid,
    output logic                   bus_ir_data_ready,
    input  logic [data_width-1:0]  bus_ir_data,
    output logic [count_width-1:0] hit_count,
    output logic [count_width-1:0] miss_count
);
    localparam int OFF_W  = $clog2(line_words);
    localparam int IDX_W  = $clog2(entries);
    localparam int SLOT_W = IDX_W + OFF_W;
    localparam int TAG_W  = addr_width - SLOT_W;
    localparam int WC_W   = OFF_W + 1;

    typedef enum logic [2:0] {CLEAR, IDLE, LOOKUP, REFILL_ADDR, REFILL_DATA, RESPOND} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0]      reset_counter;
    logic [WC_W-1:0]       word_cnt;
    logic [addr_width-1:0] req_addr;
    logic                  flush_pend;
    logic [entries-1:0]    valid_q;
    logic [TAG_W-1:0]      tag_mem  [entries];
    logic [data_width-1:0] data_mem [entries*line_words];

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WC_W-1:0]       req_off;
    logic [addr_width-1:0] line_base;
    logic                  hit;
    logic                  last_word;

    assign req_tag   = req_addr[addr_width-1:SLOT_W];
    assign req_idx   = IDX_W'(req_addr[SLOT_W-1:0] >> OFF_W);
    assign req_off   = WC_W'(req_addr[SLOT_W-1:0] & SLOT_W'(line_words-1));
    assign line_base = req_addr & ~addr_width'(line_words-1);
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign last_word = (word_cnt == WC_W'(line_words-1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= CLEAR;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR:       if (reset_counter == '0) state_nxt = IDLE;
            IDLE:        if (flush) state_nxt = CLEAR;
                         else if (ir_addr_valid) state_nxt = LOOKUP;
            LOOKUP:      state_nxt = hit ? RESPOND : REFILL_ADDR;
            REFILL_ADDR: if (bus_ir_addr_ready) state_nxt = REFILL_DATA;
            REFILL_DATA: if (bus_ir_data_valid) state_nxt = last_word ? RESPOND : REFILL_ADDR;
            RESPOND:     if (ir_data_ready) state_nxt = (flush_pend || flush) ? CLEAR : IDLE;
            default:     state_nxt = CLEAR;
        endcase
    end

    // A flush arriving in IDLE wins over a same-cycle request, so ready drops with it.
    always_comb begin
        ir_addr_ready     = (state == IDLE) && !flush;
        ir_data_valid     = (state == RESPOND);
        bus_ir_addr_valid = (state == REFILL_ADDR);
        bus_ir_data_ready = (state == REFILL_DATA);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reset_counter <= IDX_W'(entries-1);
            word_cnt      <= '0;
            req_addr      <= '0;
            flush_pend    <= 1'b0;
            bus_ir_addr   <= '0;
            ir_data       <= '0;
        end else begin
            // Decrement wraps 0 -> entries-1, re-arming the walk for the next CLEAR.
            if (state == CLEAR) reset_counter <= reset_counter - 1'b1;

            if (state == RESPOND && ir_data_ready) flush_pend <= 1'b0;
            else if (flush && state != IDLE)       flush_pend <= 1'b1;

            if (state == IDLE && ir_addr_valid && !flush) req_addr <= ir_addr;

            if (state == LOOKUP) begin
                if (hit) begin
                    ir_data <= data_mem[req_addr[SLOT_W-1:0]];
                end else begin
                    word_cnt    <= '0;
                    bus_ir_addr <= line_base;
                end
            end

            if (state == REFILL_DATA && bus_ir_data_valid) begin
                if (word_cnt == req_off) ir_data <= bus_ir_data;
                if (!last_word) begin
                    word_cnt    <= word_cnt + 1'b1;
                    bus_ir_addr <= line_base | addr_width'(word_cnt + 1'b1);
                end
            end
        end
    end

    // Valid bits are cleared by the CLEAR walk that always follows reset.
    always_ff @(posedge clock) begin
        if (state == CLEAR) valid_q[reset_counter] <= 1'b0;
        if (state == REFILL_DATA && bus_ir_data_valid) begin
            data_mem[bus_ir_addr[SLOT_W-1:0]] <= bus_ir_data;
            if (last_word) begin
                tag_mem[req_idx] <= req_tag;
                valid_q[req_idx] <= 1'b1;
            end
        end
    end

`ifdef LINE_I_CACHE_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit && hit_count != '1)         hit_count  <= hit_count + 1'b1;
            else if (!hit && miss_count != '1)  miss_count <= miss_count + 1'b1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_line_i_cache.sv
// Scoreboard bench for line_i_cache: directed fetches, bus responder model, queue-based checking.
module tb_line_i_cache;
    logic        clock, reset_n, flush;
    logic        ir_addr_valid, ir_addr_ready;
    logic [31:0] ir_addr;
    logic        ir_data_valid, ir_data_ready;
    logic [31:0] ir_data;
    logic        bus_ir_addr_valid, bus_ir_addr_ready;
    logic [31:0] bus_ir_addr;
    logic        bus_ir_data_valid, bus_ir_data_ready;
    logic [31:0] bus_ir_data;
    logic [31:0] hit_count, miss_count;

    int n_cmp = 0;
    int n_err = 0;
    int addr_stall = 0;
    logic [31:0] exp_bus[$];
    logic [31:0] exp_data[$];

    line_i_cache dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
        .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
        .bus_ir_addr_valid(bus_ir_addr_valid), .bus_ir_addr_ready(bus_ir_addr_ready),
        .bus_ir_addr(bus_ir_addr),
        .bus_ir_data_valid(bus_ir_data_valid), .bus_ir_data_ready(bus_ir_data_ready),
        .bus_ir_data(bus_ir_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus memory: word = 0xA0 + (addr & 3) + ((addr >> 8) << 4)
    function automatic logic [31:0] bus_word(input logic [31:0] a);
        return 32'hA0 + (a & 32'h3) + ((a >> 8) << 4);
    endfunction

    // Bus responder: optional addr stall, then one-cycle data beat.
    initial begin : responder
        int phase = 0;
        int stall = 0;
        logic [31:0] held = '0;
        bus_ir_addr_ready = 1'b0;
        bus_ir_data_valid = 1'b0;
        bus_ir_data       = '0;
        forever begin
            @(posedge clock); #1;
            if (!reset_n) begin
                phase = 0; stall = 0;
                bus_ir_addr_ready = 1'b0;
                bus_ir_data_valid = 1'b0;
            end else begin
                case (phase)
                    0: if (bus_ir_addr_valid) begin
                        if (stall == 0) held = bus_ir_addr;
                        else chk("bus_addr_stable", bus_ir_addr, held);
                        if (stall < addr_stall) stall++;
                        else begin bus_ir_addr_ready = 1'b1; phase = 1; end
                    end
                    1: begin
                        bus_ir_addr_ready = 1'b0;
                        bus_ir_data_valid = 1'b1;
                        bus_ir_data = bus_word(held);
                        stall = 0;
                        phase = 2;
                    end
                    default: begin
                        bus_ir_data_valid = 1'b0;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (bus_ir_addr_valid && bus_ir_addr_ready) begin
                if (exp_bus.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL bus_unexpected: got addr %0h expected no bus request", bus_ir_addr);
                end else chk("bus_addr", bus_ir_addr, exp_bus.pop_front());
            end
            if (ir_data_valid && ir_data_ready) begin
                if (exp_data.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL data_unexpected: got data %0h expected no response", ir_data);
                end else chk("ir_data", ir_data, exp_data.pop_front());
            end
        end
    end

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_bus.push_back(base + i);
    endtask

    task automatic req(input logic [31:0] a);
        int n = 0;
        @(negedge clock);
        while (!ir_addr_ready && n < 300) begin @(negedge clock); n++; end
        if (n >= 300) chk("req_ready_timeout", 0, 1);
        ir_addr = a;
        ir_addr_valid = 1'b1;
        @(posedge clock); #1;
        ir_addr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (!ir_addr_ready && n < 300) begin @(negedge clock); n++; end
        if (n >= 300) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clock);
        while (!ir_data_valid && n < 300) begin @(negedge clock); n++; end
        if (n >= 300) chk(name, 0, 1);
    endtask

    task automatic check_clear(input string name);
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (ir_addr_ready) bad++;
        end
        chk({name, "_busy"}, bad, 0);
        @(negedge clock);
        chk({name, "_ready"}, ir_addr_ready, 1);
    endtask

    task automatic chk_cnt(input int h, input int m);
`ifdef LINE_I_CACHE_PERF_EN
        chk("hit_count", hit_count, h);
        chk("miss_count", miss_count, m);
`else
        chk("hit_count", hit_count, 0);
        chk("miss_count", miss_count, 0);
        if (h < 0 || m < 0) chk("cnt_arg", 0, 1);
`endif
    endtask

    initial begin : stim
        int n;
        reset_n = 1'b0; flush = 1'b0;
        ir_addr_valid = 1'b0; ir_addr = '0; ir_data_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_ir_addr_ready", ir_addr_ready, 0);
        chk("rst_ir_data_valid", ir_data_valid, 0);
        chk("rst_bus_addr_valid", bus_ir_addr_valid, 0);
        chk("rst_bus_data_ready", bus_ir_data_ready, 0);
        chk("rst_bus_addr", bus_ir_addr, 0);
        chk("rst_ir_data", ir_data, 0);
        chk_cnt(0, 0);
        @(posedge clock); #1 reset_n = 1'b1;
        check_clear("reset_clear");

        // Cold miss: full line refill, requested word 3
        push_line(32'h78); exp_data.push_back(32'hA3);
        req(32'h7B); wait_idle();
        chk_cnt(0, 1);

        // Hit: valid exactly two cycles after transfer
        exp_data.push_back(32'hA1);
        req(32'h79);
        @(negedge clock); chk("hit_lat1", ir_data_valid, 0);
        @(negedge clock); chk("hit_lat2", ir_data_valid, 1);
        wait_idle();
        chk_cnt(1, 1);

        // Conflict on index 0xE evicts, then original misses again
        push_line(32'h178); exp_data.push_back(32'hB3);
        req(32'h17B); wait_idle();
        push_line(32'h78); exp_data.push_back(32'hA3);
        req(32'h7B); wait_idle();
        chk_cnt(1, 3);

        // Flush in IDLE: 16-cycle clear, then miss
        @(negedge clock); flush = 1'b1;
        @(posedge clock); #1 flush = 1'b0;
        check_clear("flush_clear");
        push_line(32'h78); exp_data.push_back(32'hA3);
        req(32'h7B); wait_idle();
        chk_cnt(1, 4);

        // Flush during refill: response still delivered, then clear
        push_line(32'h178); exp_data.push_back(32'hB3);
        req(32'h17B);
        n = 0;
        @(negedge clock);
        while (!bus_ir_data_ready && n < 300) begin @(negedge clock); n++; end
        if (n >= 300) chk("refill_timeout", 0, 1);
        flush = 1'b1;
        @(posedge clock); #1 flush = 1'b0;
        wait_valid("flush_resp_timeout");
        check_clear("pend_clear");
        push_line(32'h178); exp_data.push_back(32'hB3);
        req(32'h17B); wait_idle();
        chk_cnt(1, 6);

        // Backpressure on both channels
        addr_stall = 3;
        ir_data_ready = 1'b0;
        push_line(32'h278); exp_data.push_back(32'hC3);
        req(32'h27B);
        wait_valid("stall_resp_timeout");
        chk("hold_data0", ir_data, 32'hC3);
        @(negedge clock);
        chk("hold_data1", ir_data, 32'hC3);
        chk("hold_valid1", ir_data_valid, 1);
        @(posedge clock); #1 ir_data_ready = 1'b1;
        wait_idle();
        addr_stall = 0;
        chk_cnt(1, 7);

        // Reset in the middle of a refill
        exp_bus.push_back(32'h78); exp_bus.push_back(32'h79);
        req(32'h7B);
        n = 0;
        @(negedge clock);
        while (!(bus_ir_addr_valid && bus_ir_addr == 32'h7A && !bus_ir_addr_ready) && n < 300) begin
            @(negedge clock); n++;
        end
        if (n >= 300) chk("midfill_timeout", 0, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bus_valid", bus_ir_addr_valid, 0);
        chk("mid_rst_bus_addr", bus_ir_addr, 0);
        chk("mid_rst_data_ready", bus_ir_data_ready, 0);
        chk("mid_rst_ir_valid", ir_data_valid, 0);
        chk("mid_rst_ir_data", ir_data, 0);
        chk("mid_rst_addr_ready", ir_addr_ready, 0);
        chk_cnt(0, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check_clear("rst2_clear");
        push_line(32'h78); exp_data.push_back(32'hA3);
        req(32'h7B); wait_idle();
        chk_cnt(0, 1);

        repeat (3) @(negedge clock);
        chk("bus_queue_empty", exp_bus.size(), 0);
        chk("data_queue_empty", exp_data.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/line_i_cache.md
LINE_I_CACHE -- requirements
Module: line_i_cache

Interface
REQ-001 SHALL have parameter data_width, default 32, instruction word width.
REQ-002 SHALL have parameter addr_width, default 32, word-address width.
REQ-003 SHALL have parameter entries, default 16, number of lines (power of 2, >=2).
REQ-004 SHALL have parameter line_words, default 4, words per line (power of 2, >=1).
REQ-005 SHALL have parameter count_width, default 32, performance counter width.
REQ-006 SHALL have port clock  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port flush  in  1  request to invalidate all lines.
REQ-009 SHALL have ports ir_addr_valid in 1, ir_addr_ready out 1, ir_addr in addr_width: fetch request channel.
REQ-010 SHALL have ports ir_data_valid out 1, ir_data_ready in 1, ir_data out data_width: fetch response channel.
REQ-011 SHALL have ports bus_ir_addr_valid out 1, bus_ir_addr_ready in 1, bus_ir_addr out addr_width: refill request channel.
REQ-012 SHALL have ports bus_ir_data_valid in 1, bus_ir_data_ready out 1, bus_ir_data in data_width: refill response channel.
REQ-013 SHALL have ports hit_count, miss_count  out  count_width  performance counters.

Function
REQ-014 SHALL be direct-mapped; address split: offset = low log2(line_words) bits, index = next log2(entries) bits, tag = remainder.
REQ-015 SHALL implement states CLEAR, IDLE, LOOKUP, REFILL_ADDR, REFILL_DATA, RESPOND.
REQ-016 CLEAR: reset_counter walks entries-1..0 clearing one valid bit per cycle (entries cycles), then IDLE; ir_addr_ready=0 throughout.
REQ-017 IDLE: ir_addr_ready=1; transfer on ir_addr_valid&ir_addr_ready registers ir_addr, -> LOOKUP.
REQ-018 LOOKUP: hit (valid and tag match) -> RESPOND; miss -> REFILL_ADDR with word counter 0.
REQ-019 Hit: ir_data_valid SHALL rise in the second cycle after request transfer; no bus activity.
REQ-020 Refill: SHALL fetch whole line, words ascending from offset 0; bus_ir_addr = {tag,index,word counter}.
REQ-021 REFILL_ADDR: bus_ir_addr_valid=1 and bus_ir_addr stable until bus_ir_addr_ready; then REFILL_DATA.
REQ-022 REFILL_DATA: bus_ir_data_ready=1; on bus_ir_data_valid store word; if last word set tag+valid, -> RESPOND, else increment counter, -> REFILL_ADDR.
REQ-023 RESPOND: ir_data_valid=1, ir_data = stored word at requested offset, both stable until ir_data_ready; then IDLE (or CLEAR if flush pending).
REQ-024 Only one outstanding request; ir_addr_ready=0 in all states but IDLE.
REQ-025 flush in IDLE -> CLEAR next cycle; flush in any other state SHALL set a pending flag consumed on leaving RESPOND; current request completes with refilled data.
REQ-026 flush coincident with ir_addr_valid in IDLE: flush wins, request not transferred.
REQ-027 Counters increment by 1 in LOOKUP (hit or miss), saturate at all-ones, unaffected by flush.

Reset
REQ-028 On reset_n low: state CLEAR, reset_counter=entries-1, all valid/ready outputs 0, bus_ir_addr=0, ir_data=0, counters 0, flush pending 0.
REQ-029 Reset mid-refill SHALL abandon the refill immediately; partially filled line remains invalid.
REQ-030 Tag and data arrays need no reset.

Configuration
REQ-031 Macro LINE_I_CACHE_PERF_EN defined: hit_count/miss_count implemented per REQ-027.
REQ-032 Macro undefined: hit_count and miss_count SHALL be constant 0, no counter flops.

Verification (entries=16, line_words=4, PERF_EN defined)
REQ-033 Reset release -> ir_addr_ready 0 for 16 cycles, then 1; never 1 while reset_counter!=0.
REQ-034 Read 0x7B on empty cache, bus replies 0xA0..0xA3 -> bus addresses 0x78,0x79,0x7A,0x7B in order, ir_data=0xA3, miss_count=1.
REQ-035 Then read 0x79 -> ir_data=0xA1 two cycles after transfer, no bus_ir_addr_valid, hit_count=1.
REQ-036 Then read 0x17B (same index 0xE) -> refill 0x178..0x17B; subsequent read 0x7B misses again.
REQ-037 Flush pulse after line fill, read 0x7B -> 16-cycle CLEAR, then miss with full refill; flush during refill -> response delivered, then CLEAR.
REQ-038 bus_ir_addr_ready low 3 cycles, ir_data_ready low 2 cycles -> bus_ir_addr/ir_data held stable; reset_n low mid-refill -> all outputs 0, next read of same address misses.
